// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared types for the PPU pipeline hazard logic.
//   REG_AW       register-file address width
//   reg_addr_t   register address type
//   fwd_sel_t    operand source select (RF / EX / MEM / WB)
//   haz_state_t  hazard controller FSM states
// ---------------------------------------------------------------------------
package ppu_pkg;

   localparam int unsigned REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      TIMEOUT  = 2'b10
   } haz_state_t;

endpackage

// File: rtl/ppu_forward_unit.sv
// ---------------------------------------------------------------------------
// ppu_forward_unit
// Purely combinational operand-forwarding select for one source register.
// Priority is EX > MEM > WB > register file. A stage matches only when it
// writes the register file, its destination is non-zero and it equals src_i.
// Ports:
//   src_i                          source register field from ID
//   ex_rd_i / ex_rf_en_i           EX destination and write enable
//   mem_rd_i / mem_rf_en_i         MEM destination and write enable
//   wb_rd_i / wb_rf_en_i           WB destination and write enable
//   fwd_o                          selected operand source
// ---------------------------------------------------------------------------
module ppu_forward_unit
   import ppu_pkg::*;
(
   input  reg_addr_t src_i,
   input  reg_addr_t ex_rd_i,
   input  logic      ex_rf_en_i,
   input  reg_addr_t mem_rd_i,
   input  logic      mem_rf_en_i,
   input  reg_addr_t wb_rd_i,
   input  logic      wb_rf_en_i,
   output fwd_sel_t  fwd_o
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign ex_hit  = ex_rf_en_i  && (ex_rd_i  != '0) && (ex_rd_i  == src_i);
   assign mem_hit = mem_rf_en_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
   assign wb_hit  = wb_rf_en_i  && (wb_rd_i  != '0) && (wb_rd_i  == src_i);

   always_comb begin
      fwd_o = FWD_RF;
      if (ex_hit)       fwd_o = FWD_EX;
      else if (mem_hit) fwd_o = FWD_MEM;
      else if (wb_hit)  fwd_o = FWD_WB;
   end

endmodule

// File: rtl/ppu_hazard_controller.sv
// ---------------------------------------------------------------------------
// ppu_hazard_controller
// Hazard controller for the PPU five-stage pipeline: load-use and JR data
// hazard stalls, operand forwarding selects, and pipeline freeze while a
// data-memory access waits on mem_ready (with timeout to a sticky bus error).
// Output priority: freeze > load-use/JR stall > normal flow.
//
// Parameters:
//   WAIT_LIMIT   max consecutive MEM_WAIT cycles before TIMEOUT (1..255)
// Ports:
//   clk, reset                      clock, async active-low reset
//   id_rs, id_rt, id_uses_rt, id_jr ID-stage source fields and flags
//   ex_/mem_/wb_rd, *_rf_en         stage destinations and write enables
//   ex_load, mem_load               stage holds a load
//   mem_access, mem_ready           MEM access request / completion
//   ctrl_nop                        bubble select to the control unit
//   pc_le, npc_le, if_id_le         front-end load enables
//   id_ex_le, ex_mem_le, mem_wb_le  downstream pipeline-register enables
//   fwd_a, fwd_b                    forwarding selects for rs / rt
//   bus_error                       sticky memory-timeout flag
//   stall_cycles                    stall-cycle counter
// Configuration:
//   PPU_HAZARD_PERF_EN  when defined, stall_cycles is a saturating 16-bit
//                       count of clock edges with pc_le low; otherwise 0.
// ---------------------------------------------------------------------------
module ppu_hazard_controller
   import ppu_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_jr,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  mem_rd,
   input  logic [4:0]  wb_rd,
   input  logic        ex_rf_en,
   input  logic        mem_rf_en,
   input  logic        wb_rf_en,
   input  logic        ex_load,
   input  logic        mem_load,
   input  logic        mem_access,
   input  logic        mem_ready,
   output logic        ctrl_nop,
   output logic        pc_le,
   output logic        npc_le,
   output logic        if_id_le,
   output logic        id_ex_le,
   output logic        ex_mem_le,
   output logic        mem_wb_le,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        bus_error,
   output logic [15:0] stall_cycles
);

   localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

   haz_state_t state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       bus_error_q, bus_error_d;

   logic       lu_haz;
   logic       jr_haz;
   logic       freeze;
   fwd_sel_t   fwd_a_raw;
   fwd_sel_t   fwd_b_raw;

   // ---------------- forwarding ----------------
   ppu_forward_unit u_fwd_a (
      .src_i       (id_rs),
      .ex_rd_i     (ex_rd),
      .ex_rf_en_i  (ex_rf_en),
      .mem_rd_i    (mem_rd),
      .mem_rf_en_i (mem_rf_en),
      .wb_rd_i     (wb_rd),
      .wb_rf_en_i  (wb_rf_en),
      .fwd_o       (fwd_a_raw)
   );

   ppu_forward_unit u_fwd_b (
      .src_i       (id_rt),
      .ex_rd_i     (ex_rd),
      .ex_rf_en_i  (ex_rf_en),
      .mem_rd_i    (mem_rd),
      .mem_rf_en_i (mem_rf_en),
      .wb_rd_i     (wb_rd),
      .wb_rf_en_i  (wb_rf_en),
      .fwd_o       (fwd_b_raw)
   );

   assign fwd_a = reset ? fwd_a_raw : FWD_RF;
   assign fwd_b = reset ? fwd_b_raw : FWD_RF;

   // ---------------- hazard detection ----------------
   assign lu_haz = ex_load && ex_rf_en && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // JR reads its target in ID, so any EX producer or a load still in MEM
   // cannot be forwarded in time.
   assign jr_haz = id_jr &&
                   ((ex_rf_en && (ex_rd != '0) && (ex_rd == id_rs)) ||
                    (mem_load && mem_rf_en && (mem_rd != '0) && (mem_rd == id_rs)));

   always_comb begin
      freeze = 1'b0;
      case (state_q)
         RUN:      freeze = mem_access && !mem_ready;
         MEM_WAIT: freeze = !mem_ready;
         TIMEOUT:  freeze = 1'b1;
         default:  freeze = 1'b0;
      endcase
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      bus_error_d = bus_error_q;
      case (state_q)
         RUN: begin
            if (mem_access && !mem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LIMIT_C) begin
               state_d     = TIMEOUT;
               bus_error_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         TIMEOUT: begin
            state_d = TIMEOUT;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign bus_error = bus_error_q;

   // ---------------- enables / bubble select ----------------
   always_comb begin
      ctrl_nop  = 1'b0;
      pc_le     = 1'b1;
      npc_le    = 1'b1;
      if_id_le  = 1'b1;
      id_ex_le  = 1'b1;
      ex_mem_le = 1'b1;
      mem_wb_le = 1'b1;
      if (!reset) begin
         ctrl_nop  = 1'b1;
         pc_le     = 1'b0;
         npc_le    = 1'b0;
         if_id_le  = 1'b0;
         id_ex_le  = 1'b0;
         ex_mem_le = 1'b0;
         mem_wb_le = 1'b0;
      end else if (freeze) begin
         // Hold every stage; a pending load-use is re-evaluated on release.
         pc_le     = 1'b0;
         npc_le    = 1'b0;
         if_id_le  = 1'b0;
         id_ex_le  = 1'b0;
         ex_mem_le = 1'b0;
         mem_wb_le = 1'b0;
      end else if (lu_haz || jr_haz) begin
         ctrl_nop  = 1'b1;
         pc_le     = 1'b0;
         npc_le    = 1'b0;
         if_id_le  = 1'b0;
      end
   end

   // ---------------- performance counter ----------------
`ifdef PPU_HAZARD_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_le && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ppu_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_ppu_hazard_controller
// Table of combinational hazard/forwarding vectors plus hand-written
// sequences for JR double stall, memory wait, freeze-vs-load-use, timeout
// with asynchronous reset, and the stall-cycle counter.
// ---------------------------------------------------------------------------
module tb_ppu_hazard_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic        id_uses_rt, id_jr;
   logic        ex_rf_en, mem_rf_en, wb_rf_en, ex_load, mem_load;
   logic        mem_access, mem_ready;
   logic        ctrl_nop, pc_le, npc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le;
   logic [1:0]  fwd_a, fwd_b;
   logic        bus_error;
   logic [15:0] stall_cycles;

`ifdef PPU_HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   ppu_hazard_controller #(.WAIT_LIMIT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .id_jr        (id_jr),
      .ex_rd        (ex_rd),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
      .ex_rf_en     (ex_rf_en),
      .mem_rf_en    (mem_rf_en),
      .wb_rf_en     (wb_rf_en),
      .ex_load      (ex_load),
      .mem_load     (mem_load),
      .mem_access   (mem_access),
      .mem_ready    (mem_ready),
      .ctrl_nop     (ctrl_nop),
      .pc_le        (pc_le),
      .npc_le       (npc_le),
      .if_id_le     (if_id_le),
      .id_ex_le     (id_ex_le),
      .ex_mem_le    (ex_mem_le),
      .mem_wb_le    (mem_wb_le),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .bus_error    (bus_error),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] rs, rt;
      logic       uses_rt, jr;
      logic [4:0] exd, memd, wbd;
      logic       ex_en, mem_en, wb_en;
      logic       ex_ld, mem_ld;
      logic       exp_nop;
      logic [5:0] exp_le;
      logic [1:0] exp_fa, exp_fb;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [5:0] les();
      return {pc_le, npc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic idle();
      id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jr = 1'b0;
      ex_rd = '0; mem_rd = '0; wb_rd = '0;
      ex_rf_en = 1'b0; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
      ex_load = 1'b0; mem_load = 1'b0;
      mem_access = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_jr = v.jr;
      ex_rd = v.exd; mem_rd = v.memd; wb_rd = v.wbd;
      ex_rf_en = v.ex_en; mem_rf_en = v.mem_en; wb_rf_en = v.wb_en;
      ex_load = v.ex_ld; mem_load = v.mem_ld;
   endtask

   // Advance to just after the next rising edge (inputs are driven here).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cycle(input string nm, input logic nop, input logic [5:0] le);
      @(negedge clk);
      chk({nm, ".nop"}, ctrl_nop, nop);
      chk({nm, ".le"},  les(),   le);
   endtask

   initial begin
      //          rs     rt   urt  jr    exd    memd   wbd   exe  mme  wbe  exl  mml  nop   le        fa     fb
      vecs[0]  = '{5'd0, 5'd0, 1'b0,1'b0, 5'd0,  5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,6'b111111,2'b00,2'b00};
      vecs[1]  = '{5'd5, 5'd0, 1'b0,1'b0, 5'd5,  5'd0,  5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,6'b000111,2'b01,2'b00};
      vecs[2]  = '{5'd0, 5'd7, 1'b1,1'b0, 5'd7,  5'd0,  5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,6'b000111,2'b00,2'b01};
      vecs[3]  = '{5'd0, 5'd7, 1'b0,1'b0, 5'd7,  5'd0,  5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,6'b111111,2'b00,2'b01};
      vecs[4]  = '{5'd0, 5'd0, 1'b0,1'b0, 5'd0,  5'd0,  5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,6'b111111,2'b00,2'b00};
      vecs[5]  = '{5'd6, 5'd0, 1'b0,1'b0, 5'd6,  5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,6'b111111,2'b00,2'b00};
      vecs[6]  = '{5'd0, 5'd8, 1'b1,1'b0, 5'd8,  5'd8,  5'd8, 1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,6'b111111,2'b00,2'b01};
      vecs[7]  = '{5'd0, 5'd8, 1'b1,1'b0, 5'd8,  5'd8,  5'd8, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,6'b111111,2'b00,2'b10};
      vecs[8]  = '{5'd0, 5'd8, 1'b1,1'b0, 5'd8,  5'd8,  5'd8, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,6'b111111,2'b00,2'b11};
      vecs[9]  = '{5'd0, 5'd0, 1'b0,1'b0, 5'd0,  5'd0,  5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,6'b111111,2'b00,2'b00};
      vecs[10] = '{5'd3, 5'd0, 1'b0,1'b1, 5'd3,  5'd0,  5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,6'b000111,2'b01,2'b00};
      vecs[11] = '{5'd3, 5'd0, 1'b0,1'b1, 5'd0,  5'd3,  5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,6'b000111,2'b10,2'b00};
      vecs[12] = '{5'd3, 5'd0, 1'b0,1'b1, 5'd0,  5'd3,  5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,6'b111111,2'b10,2'b00};
      vecs[13] = '{5'd3, 5'd0, 1'b0,1'b0, 5'd0,  5'd3,  5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,6'b111111,2'b10,2'b00};
      vecs[14] = '{5'd4, 5'd9, 1'b1,1'b0, 5'd0,  5'd9,  5'd4, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,6'b111111,2'b11,2'b10};
      vecs[15] = '{5'd0, 5'd0, 1'b0,1'b1, 5'd0,  5'd0,  5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,6'b111111,2'b00,2'b00};
      vecs[16] = '{5'd12,5'd0, 1'b0,1'b1, 5'd0,  5'd0,  5'd12,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,6'b111111,2'b11,2'b00};

      // ---- reset state, with inputs that would otherwise stall/forward ----
      idle();
      reset = 1'b0;
      next_cycle();
      id_rs = 5'd8; ex_rd = 5'd8; ex_rf_en = 1'b1; ex_load = 1'b1;
      @(negedge clk);
      chk("rst.nop",   ctrl_nop, 1'b1);
      chk("rst.le",    les(), 6'b000000);
      chk("rst.fwd_a", fwd_a, 2'b00);
      chk("rst.berr",  bus_error, 1'b0);
      chk("rst.perf",  stall_cycles, 16'd0);
      next_cycle();
      idle();
      reset = 1'b1;

      // ---- combinational vector table (RUN, no memory access) ----
      for (int i = 0; i < 17; i++) begin
         next_cycle();
         apply(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d.nop", i),   ctrl_nop, vecs[i].exp_nop);
         chk($sformatf("vec%0d.le", i),    les(),    vecs[i].exp_le);
         chk($sformatf("vec%0d.fwd_a", i), fwd_a,    vecs[i].exp_fa);
         chk($sformatf("vec%0d.fwd_b", i), fwd_b,    vecs[i].exp_fb);
      end

      // ---- load followed by dependent JR: two stall cycles then proceed ----
      next_cycle(); idle();
      id_jr = 1'b1; id_rs = 5'd31;
      ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd31;
      chk_cycle("jr1", 1'b1, 6'b000111);
      next_cycle();
      ex_load = 1'b0; ex_rf_en = 1'b0; ex_rd = 5'd0;
      mem_load = 1'b1; mem_rf_en = 1'b1; mem_rd = 5'd31;
      chk_cycle("jr2", 1'b1, 6'b000111);
      next_cycle();
      mem_load = 1'b0; mem_rf_en = 1'b0; mem_rd = 5'd0;
      wb_rf_en = 1'b1; wb_rd = 5'd31;
      chk_cycle("jr3", 1'b0, 6'b111111);
      chk("jr3.fwd_a", fwd_a, 2'b11);

      // ---- memory wait: 3 frozen cycles, release in cycle 4, back to RUN ----
      next_cycle(); idle();
      mem_access = 1'b1; mem_ready = 1'b0;
      chk_cycle("mw1", 1'b0, 6'b000000);
      next_cycle();
      chk_cycle("mw2", 1'b0, 6'b000000);
      next_cycle();
      chk_cycle("mw3", 1'b0, 6'b000000);
      next_cycle();
      mem_ready = 1'b1;
      chk_cycle("mw4", 1'b0, 6'b111111);
      next_cycle();
      mem_access = 1'b0; mem_ready = 1'b0;  // would freeze if still in MEM_WAIT
      chk_cycle("mw5.run", 1'b0, 6'b111111);

      // ---- load-use coinciding with freeze: freeze wins, LU after release ----
      next_cycle();
      id_rs = 5'd5; ex_rd = 5'd5; ex_rf_en = 1'b1; ex_load = 1'b1;
      mem_access = 1'b1; mem_ready = 1'b0;
      chk_cycle("lufz1", 1'b0, 6'b000000);
      next_cycle();
      chk_cycle("lufz2", 1'b0, 6'b000000);
      next_cycle();
      mem_ready = 1'b1;
      chk_cycle("lufz3", 1'b1, 6'b000111);
      next_cycle(); idle();
      chk_cycle("lufz4", 1'b0, 6'b111111);

      // ---- timeout with WAIT_LIMIT=4: 5 frozen cycles then bus_error ----
      next_cycle();
      mem_access = 1'b1; mem_ready = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) next_cycle();
         @(negedge clk);
         chk($sformatf("to%0d.le", c),   les(), 6'b000000);
         chk($sformatf("to%0d.berr", c), bus_error, 1'b0);
      end
      next_cycle();
      @(negedge clk);
      chk("to6.berr", bus_error, 1'b1);
      chk("to6.le",   les(), 6'b000000);
      next_cycle();
      mem_ready = 1'b1;
      mem_access = 1'b0;
      chk_cycle("to7.frozen", 1'b0, 6'b000000);
      chk("to7.berr", bus_error, 1'b1);
      // asynchronous reset in the middle of the cycle
      #1 reset = 1'b0;
      #1;
      chk("to.rst.berr", bus_error, 1'b0);
      chk("to.rst.le",   les(), 6'b000000);
      chk("to.rst.nop",  ctrl_nop, 1'b1);
      next_cycle();
      reset = 1'b1; mem_access = 1'b0; mem_ready = 1'b0;
      chk_cycle("to.run", 1'b0, 6'b111111);

      // ---- reset mid-MEM_WAIT returns to RUN ----
      next_cycle();
      mem_access = 1'b1; mem_ready = 1'b0;
      next_cycle();
      chk_cycle("mwr.frozen", 1'b0, 6'b000000);
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      mem_access = 1'b0;
      #1;
      chk("mwr.run", les(), 6'b111111);

      // ---- stall-cycle counter: 3 load-use stalls + 2 freeze cycles ----
      next_cycle();
      idle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         id_rs = 5'd5; ex_rd = 5'd5; ex_rf_en = 1'b1; ex_load = 1'b1;
         next_cycle();
         idle();
      end
      mem_access = 1'b1; mem_ready = 1'b0;
      next_cycle();
      next_cycle();
      mem_ready = 1'b1;
      next_cycle();
      idle();
      @(negedge clk);
      chk("perf.count", stall_cycles, PERF ? 32'd5 : 32'd0);
      chk("perf.le",    les(), 6'b111111);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
